// File: rtl/wall_collision_checker_pkg.sv
// ============================================================================
// Module  : wall_pkg
// Brief   : Shared wall-map geometry, row type, FSM states and row clamping.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

package wall_pkg;

  localparam int MAP_W     = 326;
  localparam int MAP_H     = 105;
  localparam int ADDR_W    = 7;
  localparam int X_W       = 9;
  localparam int BOX_W     = 8;
  localparam int BOX_H     = 8;
  localparam int ROW_W     = $clog2(BOX_H);
  localparam int COL_IDX_W = $clog2(MAP_W);

  typedef logic [MAP_W-1:0] wall_row_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  // Keeps the ROM address inside the map even when the box hangs off the bottom.
  function automatic logic [ADDR_W-1:0] clamp_row(input logic [ADDR_W:0] row);
    if (row >= (ADDR_W+1)'(MAP_H))
      return ADDR_W'(MAP_H - 1);
    return row[ADDR_W-1:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/wall_collision_checker_if.sv
// ============================================================================
// Module  : wall_collision_checker_if
// Brief   : Request, wall-ROM and response signals of the collision checker.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

interface wall_collision_checker_if;
  import wall_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic [X_W-1:0]    req_x;
  logic [ADDR_W-1:0] req_y;
  logic [ADDR_W-1:0] rom_addr;
  wall_row_t         rom_data;
  logic              resp_valid;
  logic              resp_ready;
  logic              resp_blocked;

  // System side: movement controller plus the muxed wall ROM.
  modport master (
    output req_valid, req_x, req_y, rom_data, resp_ready,
    input  req_ready, rom_addr, resp_valid, resp_blocked
  );

  modport slave (
    input  req_valid, req_x, req_y, rom_data, resp_ready,
    output req_ready, rom_addr, resp_valid, resp_blocked
  );

endinterface

`default_nettype wire

// File: rtl/wall_collision_checker_row_window_check.sv
// ============================================================================
// Module  : row_window_check
// Brief   : Flags a wall pixel (or off-map column/row) inside the box window.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module row_window_check
  import wall_pkg::*;
(
  input  wall_row_t      row,
  input  logic [X_W-1:0] x,
  input  logic           row_off_map,
  output logic           hit
);

  logic [BOX_W-1:0] col_hit;

  // Column c lives at bit MAP_W-1-c; columns past the right edge are walls.
  for (genvar i = 0; i < BOX_W; i++) begin : g_col
    logic [X_W:0]         col;
    logic [COL_IDX_W-1:0] bit_idx;

    assign col        = {1'b0, x} + (X_W+1)'(i);
    assign bit_idx    = COL_IDX_W'(MAP_W - 1) - col[COL_IDX_W-1:0];
    assign col_hit[i] = (col >= (X_W+1)'(MAP_W)) | row[bit_idx];
  end

  assign hit = row_off_map | (|col_hit);

endmodule

`default_nettype wire

// File: rtl/wall_collision_checker.sv
// ============================================================================
// Module  : wall_collision_checker
// Brief   : Scans wall-ROM rows under a sprite box, one row per clock.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module wall_collision_checker
  import wall_pkg::*;
(
  input  logic                     Clk,
  input  logic                     Reset_n,
  wall_collision_checker_if.slave  bus
);

  state_t            state;
  state_t            next_state;
  logic [X_W-1:0]    x_lat;
  logic [ADDR_W-1:0] y_lat;
  logic [ADDR_W-1:0] row_addr;
  logic [ROW_W-1:0]  row_cnt;
  logic              blocked;

  logic [ADDR_W:0]   cur_row;
  logic [ADDR_W:0]   next_row;
  logic              row_off_map;
  logic              last_row;
  logic              hit;
  logic              accept;
  logic              advance;
  logic              finish;

  // Widened row arithmetic so rows past the map never wrap back to the top.
  assign cur_row     = {1'b0, y_lat} + (ADDR_W+1)'(row_cnt);
  assign next_row    = cur_row + (ADDR_W+1)'(1);
  assign row_off_map = (cur_row >= (ADDR_W+1)'(MAP_H));
  assign last_row    = (row_cnt == ROW_W'(BOX_H - 1));

  row_window_check u_row_check (
    .row         (bus.rom_data),
    .x           (x_lat),
    .row_off_map (row_off_map),
    .hit         (hit)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n)
      state <= IDLE;
    else
      state <= next_state;
  end

  always_comb begin
    next_state = state;
    accept     = 1'b0;
    advance    = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.req_valid) begin
          accept     = 1'b1;
          next_state = SCAN;
        end
      end
      SCAN: begin
        if (hit || last_row) begin
          finish     = 1'b1;
          next_state = DONE;
        end else begin
          advance    = 1'b1;
        end
      end
      DONE: begin
        if (bus.resp_ready)
          next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      x_lat    <= '0;
      y_lat    <= '0;
      row_addr <= '0;
      row_cnt  <= '0;
      blocked  <= 1'b0;
    end else begin
      if (accept) begin
        x_lat    <= bus.req_x;
        y_lat    <= bus.req_y;
        row_addr <= clamp_row({1'b0, bus.req_y});
        row_cnt  <= '0;
      end
      if (advance) begin
        row_cnt  <= row_cnt + ROW_W'(1);
        row_addr <= clamp_row(next_row);
      end
      if (finish)
        blocked <= hit;
    end
  end

  assign bus.req_ready    = (state == IDLE);
  assign bus.resp_valid   = (state == DONE);
  assign bus.resp_blocked = blocked;
  assign bus.rom_addr     = row_addr;

endmodule

`default_nettype wire

// File: tb/tb_wall_collision_checker.sv
// ============================================================================
// Module  : tb_wall_collision_checker
// Brief   : Vector table, corner sequences and random requests vs. a pixel model.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wall_collision_checker;
  import wall_pkg::*;

  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  wall_row_t rom [MAP_H];

  int compared = 0;
  int mismatched = 0;

  wall_collision_checker_if bus ();

  wall_collision_checker dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  always #5 Clk = ~Clk;

  assign bus.rom_data = (bus.rom_addr < ADDR_W'(MAP_H)) ? rom[bus.rom_addr] : '0;

  typedef struct {
    int wall_r;
    int wall_c;
    int x;
    int y;
    bit blk;
    int lat;
    int addr;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_rom();
    for (int r = 0; r < MAP_H; r++) rom[r] = '0;
  endtask

  // Pixel-by-pixel walk of the box: first row containing a wall or off-map pixel.
  task automatic model(input int x, input int y, output bit blk, output int k);
    blk = 1'b0;
    k = BOX_H - 1;
    for (int r = 0; r < BOX_H; r++) begin
      for (int c = x; c < x + BOX_W; c++) begin
        if (!blk && (y + r >= MAP_H || c >= MAP_W || rom[y + r][MAP_W - 1 - c] == 1'b1)) begin
          blk = 1'b1;
          k = r;
        end
      end
      if (blk) return;
    end
  endtask

  task automatic wait_resp(output int lat, output int max_addr, output bit ok);
    lat = 0;
    ok = 1'b0;
    max_addr = int'(bus.rom_addr);
    for (int i = 0; i < 40; i++) begin
      @(posedge Clk); #1;
      lat++;
      if (int'(bus.rom_addr) > max_addr) max_addr = int'(bus.rom_addr);
      if (bus.resp_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      mismatched++;
      compared++;
      $display("FAIL resp_timeout: got no resp_valid, expected one within 40 cycles");
    end
  endtask

  task automatic handshake(input string tag);
    @(negedge Clk);
    bus.resp_ready = 1'b1;
    @(posedge Clk); #1;
    bus.resp_ready = 1'b0;
    check({tag, "_valid_drop"}, int'(bus.resp_valid), 0);
    check({tag, "_ready_back"}, int'(bus.req_ready), 1);
  endtask

  task automatic run_req(input int x, input int y, output bit blk, output int lat,
                         output int last_addr, output int max_addr, output bit ok);
    @(negedge Clk);
    bus.req_valid = 1'b1;
    bus.req_x = X_W'(x);
    bus.req_y = ADDR_W'(y);
    @(posedge Clk); #1;
    bus.req_valid = 1'b0;
    wait_resp(lat, max_addr, ok);
    blk = bus.resp_blocked;
    last_addr = int'(bus.rom_addr);
  endtask

  initial begin
    bit blk, ok, exp_blk, seen;
    int lat, last_addr, max_addr, k, blk_hold;
    string tag;

    bus.req_valid = 1'b0;
    bus.req_x = '0;
    bus.req_y = '0;
    bus.resp_ready = 1'b0;
    clear_rom();

    //            wall_r wall_c   x    y  blk lat addr
    vecs[0]  = '{ -1,   -1,    10,  20, 0,  8,  27 };
    vecs[1]  = '{ 23,   15,    10,  20, 1,  4,  23 };
    vecs[2]  = '{ -1,   -1,     0, 100, 1,  6, 104 };
    vecs[3]  = '{ -1,   -1,   320,   0, 1,  1,   0 };
    vecs[4]  = '{ 27,   17,    10,  20, 1,  8,  27 };
    vecs[5]  = '{ 27,   18,    10,  20, 0,  8,  27 };
    vecs[6]  = '{ 20,   10,    10,  20, 1,  1,  20 };
    vecs[7]  = '{ -1,   -1,   318,  97, 0,  8, 104 };
    vecs[8]  = '{ -1,   -1,   319,   0, 1,  1,   0 };
    vecs[9]  = '{ -1,   -1,   511, 127, 1,  1, 104 };
    vecs[10] = '{  9,  325,   318,   2, 1,  8,   9 };
    vecs[11] = '{  0,    0,     0,   0, 1,  1,   0 };

    #3;
    check("rst_req_ready", int'(bus.req_ready), 1);
    check("rst_resp_valid", int'(bus.resp_valid), 0);
    check("rst_resp_blocked", int'(bus.resp_blocked), 0);
    check("rst_rom_addr", int'(bus.rom_addr), 0);
    @(negedge Clk);
    Reset_n = 1'b1;

    for (int v = 0; v < 12; v++) begin
      clear_rom();
      if (vecs[v].wall_r >= 0) rom[vecs[v].wall_r][MAP_W - 1 - vecs[v].wall_c] = 1'b1;
      run_req(vecs[v].x, vecs[v].y, blk, lat, last_addr, max_addr, ok);
      tag = $sformatf("vec%0d", v);
      if (ok) begin
        check({tag, "_blocked"}, int'(blk), int'(vecs[v].blk));
        check({tag, "_latency"}, lat, vecs[v].lat);
        check({tag, "_last_addr"}, last_addr, vecs[v].addr);
        check({tag, "_addr_in_map"}, int'(max_addr <= MAP_H - 1), 1);
      end
      handshake(tag);
    end

    // Reset in the middle of a scan discards the request.
    clear_rom();
    @(negedge Clk);
    bus.req_valid = 1'b1;
    bus.req_x = 9'd10;
    bus.req_y = 7'd20;
    @(posedge Clk); #1;
    bus.req_valid = 1'b0;
    repeat (3) @(posedge Clk);
    #2;
    Reset_n = 1'b0;
    #1;
    check("midscan_rst_req_ready", int'(bus.req_ready), 1);
    check("midscan_rst_resp_valid", int'(bus.resp_valid), 0);
    check("midscan_rst_rom_addr", int'(bus.rom_addr), 0);
    @(negedge Clk);
    Reset_n = 1'b1;
    seen = 1'b0;
    repeat (15) begin
      @(posedge Clk); #1;
      if (bus.resp_valid) seen = 1'b1;
    end
    check("midscan_no_response", int'(seen), 0);

    // Backpressure: result held while a new request waits.
    clear_rom();
    run_req(10, 20, blk, lat, last_addr, max_addr, ok);
    check("bp_first_latency", lat, 8);
    @(negedge Clk);
    bus.req_valid = 1'b1;
    bus.req_x = 9'd320;
    bus.req_y = 7'd3;
    blk_hold = int'(bus.resp_blocked);
    seen = 1'b0;
    repeat (10) begin
      @(posedge Clk); #1;
      if (!bus.resp_valid || bus.req_ready || int'(bus.resp_blocked) != blk_hold) seen = 1'b1;
    end
    check("bp_held_stable", int'(seen), 0);
    check("bp_blocked_value", blk_hold, 0);
    @(negedge Clk);
    bus.resp_ready = 1'b1;
    @(posedge Clk); #1;
    bus.resp_ready = 1'b0;
    check("bp_idle_ready", int'(bus.req_ready), 1);
    check("bp_idle_valid", int'(bus.resp_valid), 0);
    @(posedge Clk); #1;
    bus.req_valid = 1'b0;
    check("bp_accepted", int'(bus.req_ready), 0);
    check("bp_new_addr", int'(bus.rom_addr), 3);
    wait_resp(lat, max_addr, ok);
    if (ok) begin
      check("bp_second_blocked", int'(bus.resp_blocked), 1);
      check("bp_second_latency", lat, 1);
    end
    handshake("bp");

    // Random requests against a sparse random wall map.
    for (int n = 0; n < 60; n++) begin
      for (int r = 0; r < MAP_H; r++) begin
        rom[r] = '0;
        repeat ($urandom_range(0, 4)) rom[r][$urandom_range(0, MAP_W - 1)] = 1'b1;
      end
      begin
        int x, y;
        x = ($urandom_range(0, 7) == 0) ? int'($urandom_range(300, 511)) : int'($urandom_range(0, 330));
        y = ($urandom_range(0, 7) == 0) ? int'($urandom_range(95, 127)) : int'($urandom_range(0, 104));
        model(x, y, exp_blk, k);
        run_req(x, y, blk, lat, last_addr, max_addr, ok);
        tag = $sformatf("rnd%0d_x%0d_y%0d", n, x, y);
        if (ok) begin
          check({tag, "_blocked"}, int'(blk), int'(exp_blk));
          check({tag, "_latency"}, lat, exp_blk ? k + 1 : BOX_H);
          check({tag, "_last_addr"}, last_addr, (y + k > MAP_H - 1) ? MAP_H - 1 : y + k);
        end
        handshake(tag);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/wall_collision_checker.md
Name: wall_collision_checker

Overview:
- Reader side of the wall-map ROMs (326-bit rows, 105 rows, 7-bit row address, combinational data).
- Takes a sprite position request and scans the ROM rows under the sprite's bounding box, one row per clock.
- Reports whether any wall pixel overlaps the box.
- Sits between the Pac-Man/ghost movement controllers and whichever wall ROM is muxed onto its ROM port.

Parameters:
- MAP_W, 326, wall-map width in pixels (ROM data width)
- MAP_H, 105, wall-map height in rows
- ADDR_W, 7, ROM row address width
- X_W, 9, request x-coordinate width
- BOX_W, 8, sprite bounding-box width in pixels
- BOX_H, 8, sprite bounding-box height in rows

Ports:
- Clk  input  1  system clock, all state on rising edge
- Reset_n  input  1  asynchronous active-low reset
- req_valid  input  1  request present
- req_ready  output  1  block can accept a request (IDLE only)
- req_x  input  X_W  left column of box
- req_y  input  ADDR_W  top row of box
- rom_addr  output  ADDR_W  row address to wall ROM (registered)
- rom_data  input  MAP_W  row data from ROM, valid in the same cycle as rom_addr
- resp_valid  output  1  result available
- resp_ready  input  1  consumer accepts result
- resp_blocked  output  1  1 = box overlaps a wall or leaves the map

Behaviour:
- Reset (async, Reset_n=0):
  - state IDLE; req_ready=1, resp_valid=0, resp_blocked=0, rom_addr=0, row counter=0.
  - Takes effect immediately, including mid-SCAN or in DONE. Any in-flight request is discarded with no response.
- States:
  - IDLE: req_ready=1. When req_valid&&req_ready, latch x,y; rom_addr<=y (clamped); r<=0; go to SCAN.
  - SCAN: req_ready=0. Evaluate row r using the current rom_data.
    - hit -> resp_blocked<=1, go to DONE.
    - else if r==BOX_H-1 -> resp_blocked<=0, go to DONE.
    - else r<=r+1, rom_addr<=clamp(y+r+1).
  - DONE: resp_valid=1, resp_blocked held stable. On resp_ready go to IDLE and drop resp_valid. req_valid is ignored here.
- Pixel mapping: column c of a row is rom_data[MAP_W-1-c] (MSB = leftmost pixel).
- Row hit: any column c in [x, x+BOX_W-1] with that bit set.
- Off-map rules:
  - Any column >= MAP_W counts as a wall.
  - Any row y+r >= MAP_H counts as a wall (hit), regardless of rom_data.
- Arithmetic: y+r computed in ADDR_W+1 bits, x+i in X_W+1 bits; no wrap-around.
- Clamping: rom_addr never exceeds MAP_H-1.
- Latency, with accept at cycle t:
  - hit in row k: resp_valid first high at t+2+k.
  - clear: resp_valid first high at t+1+BOX_H.
  - Minimum request-to-request spacing: BOX_H+2 cycles with resp_ready held high.

Decomposition:
- Shared package wall_pkg:
  - MAP_W, MAP_H, ADDR_W constants.
  - Typedef wall_row_t = logic [MAP_W-1:0].
  - State enum {IDLE, SCAN, DONE}.
- One combinational sub-module, row_window_check: inputs row (wall_row_t), x, row_off_map; output hit. Applies the column mapping and off-map rules.
- The FSM and counters stay in wall_collision_checker.

Test Plan:
1. Reset_n pulsed low mid-SCAN (request x=10,y=20, 3 cycles after accept) -> immediately req_ready=1, resp_valid=0, rom_addr=0. No response is ever produced for that request.
2. Model ROM all zeros, request x=10,y=20 accepted at t -> rom_addr steps 20..27 on cycles t+1..t+8; resp_valid at t+9 with resp_blocked=0.
3. Model ROM zeros except row 23, bit (325-15) set; request x=10,y=20 -> hit at r=3; resp_valid at t+5, resp_blocked=1; rom_addr last value 23.
4. All-zero ROM, request x=0,y=100 -> row 105 (r=5) is off-map; resp_blocked=1 at t+7; rom_addr never exceeds 104.
5. All-zero ROM, request x=320,y=0 -> columns 326/327 are off-map; hit at r=0; resp_valid at t+2, resp_blocked=1.
6. Backpressure: resp_ready low for 10 cycles in DONE with req_valid held high -> resp_valid and resp_blocked stable, req_ready=0, no new accept. After resp_ready=1, IDLE next cycle and the pending request is accepted that cycle.
